// File: rtl/alu_issue_ctrl.sv
// Issue sequencer for a fixed-latency ALU: reads operands from an 8x16 register file,
// drives the ALU, captures result/flags, writes back and returns them over valid/ready.
module alu_issue_ctrl #(
  parameter int unsigned ALU_LAT = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        instr_valid,
  output logic        instr_ready,
  input  logic [15:0] instr,
  input  logic        ld_en,
  input  logic [2:0]  ld_addr,
  input  logic [15:0] ld_data,
  output logic [15:0] alu_a,
  output logic [15:0] alu_b,
  output logic [2:0]  alu_opcode,
  output logic        alu_mode,
  input  logic [31:0] alu_result,
  input  logic [4:0]  alu_flags,
  output logic        res_valid,
  input  logic        res_ready,
  output logic [31:0] res_data,
  output logic [4:0]  res_flags,
  output logic        busy
);

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT,
    CAPTURE,
    RESP
  } state_t;

  localparam logic [3:0] CNT_INIT = 4'(ALU_LAT - 1);

  state_t      state;
  logic [15:0] regs [8];
  logic [2:0]  rd_q;
  logic [2:0]  ra_q;
  logic [2:0]  rb_q;
  logic [2:0]  op_q;
  logic        mode_q;
  logic [3:0]  cnt;

  // The reserved instruction field is deliberately ignored.
  logic unused_rsv;
  assign unused_rsv = ^instr[2:0];

  // A load has priority over an instruction offered in the same IDLE cycle.
  assign instr_ready = (state == IDLE) && !ld_en;
  assign busy        = (state != IDLE);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      // NOTE: the register file is explicitly cleared on reset, so it is built from flops rather than a RAM macro.
      for (int i = 0; i < 8; i++) regs[i] <= '0;
      rd_q       <= '0;
      ra_q       <= '0;
      rb_q       <= '0;
      op_q       <= '0;
      mode_q     <= 1'b0;
      cnt        <= '0;
      alu_a      <= '0;
      alu_b      <= '0;
      alu_opcode <= '0;
      alu_mode   <= 1'b0;
      res_valid  <= 1'b0;
      res_data   <= '0;
      res_flags  <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (ld_en) begin
            regs[ld_addr] <= ld_data;
          end else if (instr_valid) begin
            mode_q <= instr[15];
            op_q   <= instr[14:12];
            rd_q   <= instr[11:9];
            ra_q   <= instr[8:6];
            rb_q   <= instr[5:3];
            state  <= ISSUE;
          end
        end
        ISSUE: begin
          // Operands are read here, before writeback, so rd==ra/rb sees the old value.
          alu_a      <= regs[ra_q];
          alu_b      <= regs[rb_q];
          alu_opcode <= op_q;
          alu_mode   <= mode_q;
          cnt        <= CNT_INIT;
          state      <= WAIT;
        end
        WAIT: begin
          if (cnt == 4'd0) state <= CAPTURE;
          else             cnt   <= cnt - 4'd1;
        end
        CAPTURE: begin
          res_data     <= alu_result;
          res_flags    <= alu_flags;
          regs[rd_q]   <= alu_result[15:0];
          res_valid    <= 1'b1;
          state        <= RESP;
        end
        RESP: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
